pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/hazard_pkg.sv | 9 +
 rtl/sat_counter.sv | 17 +
 rtl/pipeline_hazard_controller.sv | 92 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and load-use bubble-count limits.
package hazard_pkg;
   typedef enum logic {IDLE, LOAD_STALL} state_e;
   localparam int STALL_MIN = 1;
   localparam int STALL_MAX = 15;
   function automatic int clamp_stalls(input int n);
      return n < STALL_MIN ? STALL_MIN : n > STALL_MAX ? STALL_MAX : n;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count
);
   logic [CNT_WIDTH-1:0] count_q, count_d;
   always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + CNT_WIDTH'(1) : count_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) count_q <= '0;
      else count_q <= count_d;
   assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, branch flush and memory-freeze control
// for a five-stage pipeline, with saturating stall/flush performance counters.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH        = 5,
   parameter int LOAD_USE_STALL_CYCLES = 1,
   parameter int CNT_WIDTH             = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic                      branch_taken_ex,
   input  logic                      mem_busy,
   input  logic                      clear_counters,
   output logic                      pc_write,
   output logic                      if_id_write,
   output logic                      id_ex_write,
   output logic                      ex_mem_write,
   output logic                      if_id_flush,
   output logic                      id_ex_bubble,
   output logic [CNT_WIDTH-1:0]      stall_cycles,
   output logic [CNT_WIDTH-1:0]      flush_count
);
   localparam int STALLS = clamp_stalls(LOAD_USE_STALL_CYCLES);
   localparam logic [3:0] REM_INIT = 4'(STALLS - 1);

   state_e     state_q, state_d;
   logic [3:0] rem_q, rem_d;
   logic       hazard, run, stall, flush;

   assign hazard = ex_mem_read && ex_rd != '0 &&
                   ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end

   // The hazard cycle itself is the first bubble, so only STALLS-1 remain afterwards.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (!mem_busy) begin
         if (state_q == LOAD_STALL) begin
            rem_d   = rem_q - 4'd1;
            state_d = rem_q == 4'd1 ? IDLE : LOAD_STALL;
         end else if (!branch_taken_ex && hazard && STALLS > 1) begin
            state_d = LOAD_STALL;
            rem_d   = REM_INIT;
         end
      end
   end

   // Reset gates every enable low immediately, independent of the clock.
   always_comb begin
      run          = reset_n && !mem_busy;
      stall        = run && (state_q == LOAD_STALL || (!branch_taken_ex && hazard));
      flush        = run && state_q == IDLE && branch_taken_ex;
      pc_write     = run && !stall;
      if_id_write  = run && !stall;
      id_ex_write  = run;
      ex_mem_write = run;
      if_id_flush  = flush;
      id_ex_bubble = stall || flush;
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (!pc_write),
      .clr     (clear_counters),
      .count   (stall_cycles)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (if_id_flush),
      .clr     (clear_counters),
      .count   (flush_count)
   );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: two instances (1 bubble / 32-bit counters and
// 3 bubbles / 4-bit counters) driven in parallel and checked against a bubble-queue model.
module tb_pipeline_hazard_controller;
   logic       clk = 0, reset_n = 1;
   logic       ex_mem_read = 0, id_rs1_used = 0, id_rs2_used = 0;
   logic [4:0] ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
   logic       branch_taken_ex = 0, mem_busy = 0, clear_counters = 0;

   logic        pcw1, ifw1, idw1, exw1, fl1, bub1;
   logic        pcw3, ifw3, idw3, exw3, fl3, bub3;
   logic [31:0] sc1, fc1;
   logic [3:0]  sc3, fc3;
   logic [5:0]  outs1, outs3;

   int     n_cmp = 0, n_err = 0;
   int     pend1 = 0, pend3 = 0;
   longint s1 = 0, f1 = 0, s3 = 0, f3 = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller u1 (
      .clk(clk), .reset_n(reset_n), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy), .clear_counters(clear_counters),
      .pc_write(pcw1), .if_id_write(ifw1), .id_ex_write(idw1), .ex_mem_write(exw1),
      .if_id_flush(fl1), .id_ex_bubble(bub1), .stall_cycles(sc1), .flush_count(fc1));

   pipeline_hazard_controller #(.LOAD_USE_STALL_CYCLES(3), .CNT_WIDTH(4)) u3 (
      .clk(clk), .reset_n(reset_n), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy), .clear_counters(clear_counters),
      .pc_write(pcw3), .if_id_write(ifw3), .id_ex_write(idw3), .ex_mem_write(exw3),
      .if_id_flush(fl3), .id_ex_bubble(bub3), .stall_cycles(sc3), .flush_count(fc3));

   assign outs1 = {pcw1, ifw1, idw1, exw1, fl1, bub1};
   assign outs3 = {pcw3, ifw3, idw3, exw3, fl3, bub3};

   typedef struct {
      logic       ld;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, br, busy;
      logic [5:0] exp;
   } vec_t;
   vec_t tv[12];

   function automatic logic hz();
      return ex_mem_read && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
   endfunction

   // Expected {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble}.
   function automatic logic [5:0] model_out(input int pend);
      logic st, fl;
      if (!reset_n || mem_busy) return 6'b0;
      st = pend > 0 || (!branch_taken_ex && hz());
      fl = !st && branch_taken_ex;
      return {!st, !st, 1'b1, 1'b1, fl, st || fl};
   endfunction

   task automatic upd(inout int pend, inout longint s, inout longint f,
                      input int bubbles, input longint mx, input logic [5:0] e);
      if (clear_counters) begin
         s = 0;
         f = 0;
      end else begin
         if (!e[5] && s < mx) s++;
         if (e[1] && f < mx) f++;
      end
      if (!mem_busy) begin
         if (pend > 0) pend--;
         else if (!branch_taken_ex && hz()) pend = bubbles - 1;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ld, input logic [4:0] rd, rs1, rs2,
                        input logic u1_, u2_, br, busy, clr);
      ex_mem_read = ld; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_rs1_used = u1_; id_rs2_used = u2_; branch_taken_ex = br;
      mem_busy = busy; clear_counters = clr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
   endtask

   // Inputs are applied 1 unit after a rising edge; outputs checked mid-cycle, counters after the edge.
   task automatic step(input logic tv_en = 0, input logic [5:0] tv_exp = 0);
      logic [5:0] e1, e3;
      #3;
      e1 = model_out(pend1);
      e3 = model_out(pend3);
      chk("outs_l1", {58'd0, outs1}, {58'd0, e1});
      chk("outs_l3", {58'd0, outs3}, {58'd0, e3});
      if (tv_en) chk("table_outs", {58'd0, outs1}, {58'd0, tv_exp});
      @(posedge clk);
      upd(pend1, s1, f1, 1, 64'hFFFF_FFFF, e1);
      upd(pend3, s3, f3, 3, 15, e3);
      #1;
      chk("stall_l1", {32'd0, sc1}, s1);
      chk("flush_l1", {32'd0, fc1}, f1);
      chk("stall_l3", {60'd0, sc3}, s3);
      chk("flush_l3", {60'd0, fc3}, f3);
   endtask

   initial begin
      tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 6'b111100};
      tv[1]  = '{1, 5, 5, 0, 1, 0, 0, 0, 6'b001101};
      tv[2]  = '{1, 0, 0, 0, 0, 1, 0, 0, 6'b111100};
      tv[3]  = '{1, 5, 5, 0, 0, 0, 0, 0, 6'b111100};
      tv[4]  = '{1, 7, 0, 7, 0, 1, 0, 0, 6'b001101};
      tv[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 6'b111111};
      tv[6]  = '{1, 5, 5, 0, 1, 0, 1, 0, 6'b111111};
      tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 6'b000000};
      tv[8]  = '{1, 5, 5, 0, 1, 0, 0, 1, 6'b000000};
      tv[9]  = '{0, 5, 5, 0, 1, 0, 0, 0, 6'b111100};
      tv[10] = '{1, 3, 4, 3, 1, 1, 0, 0, 6'b001101};
      tv[11] = '{1, 3, 0, 3, 0, 0, 0, 0, 6'b111100};

      #1 reset_n = 0;
      #2;
      chk("reset_outs_l1", {58'd0, outs1}, 0);
      chk("reset_outs_l3", {58'd0, outs3}, 0);
      chk("reset_stall_l1", {32'd0, sc1}, 0);
      chk("reset_flush_l3", {60'd0, fc3}, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;

      for (int i = 0; i < 12; i++) begin
         drive(tv[i].ld, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2, tv[i].br, tv[i].busy, 0);
         step(1, tv[i].exp);
      end

      // Single load-use hazard: one bubble at depth 1, three at depth 3.
      idle(4);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      drive(1, 5, 5, 0, 1, 0, 0, 0, 0); step();
      idle(4);
      chk("one_bubble_count", {32'd0, sc1}, 1);
      chk("three_bubble_count", {60'd0, sc3}, 3);

      // Branch beats a simultaneous hazard.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      drive(1, 5, 5, 0, 1, 0, 1, 0, 0); step();
      idle(4);
      chk("branch_flush_l1", {32'd0, fc1}, 1);
      chk("branch_flush_l3", {60'd0, fc3}, 1);
      chk("branch_nostall_l3", {60'd0, sc3}, 0);

      // Memory freeze in the middle of a three-bubble stall.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      drive(1, 5, 5, 0, 1, 0, 0, 0, 0); step();
      idle(1);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         step();
      end
      idle(3);
      chk("freeze_stall_l3", {60'd0, sc3}, 7);
      chk("freeze_stall_l1", {32'd0, sc1}, 5);

      // Asynchronous reset mid-stall.
      idle(2);
      drive(1, 5, 5, 0, 1, 0, 0, 0, 0); step();
      #2 reset_n = 0;
      #1;
      pend1 = 0; pend3 = 0; s1 = 0; f1 = 0; s3 = 0; f3 = 0;
      chk("midstall_reset_outs", {58'd0, outs3}, 0);
      chk("midstall_reset_stall", {60'd0, sc3}, 0);
      chk("midstall_reset_flush_l1", {32'd0, fc1}, 0);
      @(posedge clk);
      #1 reset_n = 1;
      idle(1);

      // Saturation of the 4-bit counter.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         step();
      end
      chk("saturate_l3", {60'd0, sc3}, 15);
      chk("no_saturate_l1", {32'd0, sc1}, 20);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
